// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Shares one single-port synchronous data memory between the CPU
//            load/store path and a debug/DMA port, and stalls the datapath.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int Dbits   = 32,
  parameter int MEM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [Dbits-1:0] cpu_addr,
  input  logic [Dbits-1:0] cpu_wdata,
  output logic [Dbits-1:0] cpu_rdata,
  output logic             cpu_enable,
  input  logic             dbg_req,
  input  logic             dbg_we,
  input  logic [Dbits-1:0] dbg_addr,
  input  logic [Dbits-1:0] dbg_wdata,
  output logic             dbg_gnt,
  output logic             dbg_rvalid,
  output logic [Dbits-1:0] dbg_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [Dbits-1:0] mem_addr,
  output logic [Dbits-1:0] mem_wdata,
  input  logic [Dbits-1:0] mem_rdata
);

  localparam int                 c_cnt_w    = $clog2(MEM_LAT + 1);
  localparam logic [c_cnt_w-1:0] c_lat      = c_cnt_w'(MEM_LAT);
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
  localparam logic               c_last_dbg = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CRD   = 2'd1,
    S_CDONE = 2'd2,
    S_DRD   = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
  logic               r_last, w_last_nxt;
  logic [Dbits-1:0]   r_cpu_rdata, r_dbg_rdata;
  logic               r_dbg_rvalid;
  logic               w_issue, w_win_dbg, w_cpu_enable, w_cpu_cap, w_dbg_cap;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_last_nxt   = r_last;
    w_issue      = 1'b0;
    w_win_dbg    = 1'b0;
    w_cpu_enable = 1'b1;
    w_cpu_cap    = 1'b0;
    w_dbg_cap    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_issue = cpu_req | dbg_req;
        // On a tie the requester that did not win last time goes first.
        w_win_dbg = dbg_req & ~(cpu_req & (r_last == c_last_dbg));
        if (w_issue) begin
          w_last_nxt = w_win_dbg;
          if (w_win_dbg) begin
            w_cpu_enable = ~cpu_req;
            if (!dbg_we) begin
              w_state_nxt = S_DRD;
              w_cnt_nxt   = c_lat;
            end
          end else if (!cpu_we) begin
            w_cpu_enable = 1'b0;
            w_state_nxt  = S_CRD;
            w_cnt_nxt    = c_lat;
          end
        end
      end
      S_CRD: begin
        w_cpu_enable = 1'b0;
        w_cnt_nxt    = r_cnt - c_one;
        if (r_cnt == c_one) begin
          w_cpu_cap   = 1'b1;
          w_state_nxt = S_CDONE;
        end
      end
      S_CDONE: begin
        w_state_nxt = S_IDLE;
      end
      S_DRD: begin
        w_cpu_enable = ~cpu_req;
        w_cnt_nxt    = r_cnt - c_one;
        if (r_cnt == c_one) begin
          w_dbg_cap   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_last       <= c_last_dbg;
      r_cpu_rdata  <= '0;
      r_dbg_rdata  <= '0;
      r_dbg_rvalid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_last       <= w_last_nxt;
      r_dbg_rvalid <= w_dbg_cap;
      if (w_cpu_cap) r_cpu_rdata <= mem_rdata;
      if (w_dbg_cap) r_dbg_rdata <= mem_rdata;
    end
  end

  // Combinational outputs are forced quiet while reset is held.
  assign mem_en     = w_issue & ~reset;
  assign mem_we     = mem_en & (w_win_dbg ? dbg_we : cpu_we);
  assign mem_addr   = mem_en ? (w_win_dbg ? dbg_addr : cpu_addr) : '0;
  assign mem_wdata  = mem_en ? (w_win_dbg ? dbg_wdata : cpu_wdata) : '0;
  assign dbg_gnt    = mem_en & w_win_dbg;
  assign cpu_enable = w_cpu_enable & ~reset;
  assign cpu_rdata  = r_cpu_rdata;
  assign dbg_rdata  = r_dbg_rdata;
  assign dbg_rvalid = r_dbg_rvalid;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter at memory latencies 1, 2, 3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  logic clk;
  int   n_vec = 0;
  int   n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  function automatic op_t mk(input bit req, input bit we, input int w, input logic [31:0] d);
    op_t o;
    o.req  = req;
    o.we   = we;
    o.addr = 32'h1001_0000 + 32'(w * 4);
    o.data = d;
    return o;
  endfunction

  for (genvar gi = 0; gi < 3; gi++) begin : g_inst
    localparam int LAT = gi + 1;

    logic        reset, cpu_req, cpu_we, dbg_req, dbg_we;
    logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
    logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_enable, dbg_gnt, dbg_rvalid, mem_en, mem_we;
    logic [31:0] mem  [8];
    logic [31:0] pipe [LAT];
    bit          fin = 1'b0;

    dmem_arbiter #(.Dbits(32), .MEM_LAT(LAT)) u_dut (
      .clk       (clk),
      .reset     (reset),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .cpu_enable(cpu_enable),
      .dbg_req   (dbg_req),
      .dbg_we    (dbg_we),
      .dbg_addr  (dbg_addr),
      .dbg_wdata (dbg_wdata),
      .dbg_gnt   (dbg_gnt),
      .dbg_rvalid(dbg_rvalid),
      .dbg_rdata (dbg_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
    );

    // Memory: read data appears LAT cycles after the issue cycle.
    always @(posedge clk) begin
      if (mem_en && mem_we) mem[mem_addr[4:2]] <= mem_wdata;
      pipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[4:2]] : 32'h0;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = pipe[LAT-1];

    // Reference model: timestamps of when the port frees up and data lands.
    int          n = 0, free_at = 0, cpu_done_at = -1, dbg_valid_at = -1;
    bit          last_dbg = 1'b1;
    logic [31:0] shadow [8];
    logic [31:0] e_cpu_rdata = '0, e_dbg_rdata = '0, pend_cpu = '0, pend_dbg = '0;
    op_t         cur_c = '0, cur_d = '0;
    op_t         cq [$];
    op_t         dq [$];
    bit          c_ret = 1'b1, d_gnt = 1'b1;
    int          obs_we, obs_en, obs_stall, obs_gnt_n, obs_rv_n;

    task automatic clr_obs();
      obs_we = 0; obs_en = 0; obs_stall = 0; obs_gnt_n = -1; obs_rv_n = -1;
    endtask

    task automatic drive(input bit rst_v);
      @(posedge clk);
      #1;
      reset = rst_v;
      if (c_ret) begin
        if (cq.size() > 0) cur_c = cq.pop_front();
        else cur_c = '0;
      end
      if (d_gnt || !cur_d.req) begin
        if (dq.size() > 0) cur_d = dq.pop_front();
        else cur_d = '0;
      end
      cpu_req = cur_c.req; cpu_we = cur_c.we; cpu_addr = cur_c.addr; cpu_wdata = cur_c.data;
      dbg_req = cur_d.req; dbg_we = cur_d.we; dbg_addr = cur_d.addr; dbg_wdata = cur_d.data;
    endtask

    task automatic tick();
      logic        x_cen, x_en, x_we, x_gnt, x_rv;
      logic [31:0] x_addr, x_wd;
      bit          win_dbg;
      string       p;
      @(negedge clk);
      p = $sformatf("L%0d.c%0d", LAT, n);
      {x_cen, x_en, x_we, x_gnt, x_rv} = '0;
      x_addr = '0; x_wd = '0;
      c_ret = 1'b0; d_gnt = 1'b0;
      if (reset) begin
        free_at = n + 1; cpu_done_at = -1; dbg_valid_at = -1; last_dbg = 1'b1;
        e_cpu_rdata = '0; e_dbg_rdata = '0;
      end else begin
        if (n == cpu_done_at) e_cpu_rdata = pend_cpu;
        if (n == dbg_valid_at) e_dbg_rdata = pend_dbg;
        x_rv = (n == dbg_valid_at);
        if (n >= free_at) begin
          x_cen = 1'b1;
          if (cur_c.req || cur_d.req) begin
            win_dbg  = cur_d.req && !(cur_c.req && last_dbg);
            last_dbg = win_dbg;
            x_en     = 1'b1;
            if (win_dbg) begin
              x_gnt = 1'b1; d_gnt = 1'b1; x_cen = !cur_c.req;
              x_we = cur_d.we; x_addr = cur_d.addr; x_wd = cur_d.data;
              if (cur_d.we) shadow[cur_d.addr[4:2]] = cur_d.data;
              else begin
                pend_dbg = shadow[cur_d.addr[4:2]];
                dbg_valid_at = n + LAT + 1;
                free_at = n + LAT + 1;
              end
            end else begin
              x_we = cur_c.we; x_addr = cur_c.addr; x_wd = cur_c.data;
              if (cur_c.we) shadow[cur_c.addr[4:2]] = cur_c.data;
              else begin
                pend_cpu = shadow[cur_c.addr[4:2]];
                cpu_done_at = n + LAT + 1;
                free_at = n + LAT + 2;
                x_cen = 1'b0;
              end
            end
          end
        end else begin
          x_cen = (n == cpu_done_at) || (n > cpu_done_at && !cur_c.req);
        end
        c_ret = x_cen;
      end
      chk_val({p, ".cpu_enable"}, 32'(cpu_enable), 32'(x_cen));
      chk_val({p, ".mem_en"},     32'(mem_en),     32'(x_en));
      chk_val({p, ".mem_we"},     32'(mem_we),     32'(x_we));
      chk_val({p, ".mem_addr"},   mem_addr,        x_addr);
      chk_val({p, ".mem_wdata"},  mem_wdata,       x_wd);
      chk_val({p, ".dbg_gnt"},    32'(dbg_gnt),    32'(x_gnt));
      chk_val({p, ".dbg_rvalid"}, 32'(dbg_rvalid), 32'(x_rv));
      chk_val({p, ".cpu_rdata"},  cpu_rdata,       e_cpu_rdata);
      chk_val({p, ".dbg_rdata"},  dbg_rdata,       e_dbg_rdata);
      if (mem_en) obs_en++;
      if (mem_en && mem_we) obs_we++;
      if (cpu_req && !cpu_enable && !reset) obs_stall++;
      if (dbg_gnt) obs_gnt_n = n;
      if (dbg_rvalid) obs_rv_n = n;
      n++;
    endtask

    task automatic run(input int max_cyc, input int rst_at, input int rst_len);
      int k;
      bit q;
      k = 0; q = 1'b0;
      while (!q && k < max_cyc) begin
        drive(k >= rst_at && k < rst_at + rst_len);
        tick();
        k++;
        q = (k >= rst_at + rst_len) && cq.size() == 0 && dq.size() == 0 && c_ret &&
            (d_gnt || !cur_d.req) && n >= free_at && n > cpu_done_at && n > dbg_valid_at;
      end
      chk_val($sformatf("L%0d.drain", LAT), 32'(q), 32'd1);
    endtask

    initial begin : p_stim
      reset = 1'b1;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;

      // Reset, then eight back-to-back CPU stores.
      clr_obs();
      cq.push_back(mk(1, 1, 0, 32'hDEAD_BEEF));
      for (int w = 1; w < 8; w++) cq.push_back(mk(1, 1, w, 32'(w) * 32'h1111_1111));
      run(100, 0, 2);
      chk_val($sformatf("L%0d.store_we_pulses", LAT), 32'(obs_we), 32'd8);
      chk_val($sformatf("L%0d.store_stalls", LAT), 32'(obs_stall), 32'd0);

      // Single CPU load.
      clr_obs();
      cq.push_back(mk(1, 0, 0, 32'h0));
      run(50, -1, 0);
      chk_val($sformatf("L%0d.load_stalls", LAT), 32'(obs_stall), 32'(LAT + 1));
      chk_val($sformatf("L%0d.load_en_pulses", LAT), 32'(obs_en), 32'd1);
      chk_val($sformatf("L%0d.load_data", LAT), cpu_rdata, 32'hDEAD_BEEF);

      // Debug read latency from grant to rvalid.
      clr_obs();
      dq.push_back(mk(1, 0, 2, 32'h0));
      run(50, -1, 0);
      chk_val($sformatf("L%0d.dbg_rd_lat", LAT), 32'(obs_rv_n - obs_gnt_n), 32'(LAT + 1));
      chk_val($sformatf("L%0d.dbg_rd_data", LAT), dbg_rdata, 32'h2222_2222);

      // Ties from reset release, then a repeated tie.
      clr_obs();
      cq.push_back(mk(1, 1, 3, 32'hA3A3_A3A3));
      cq.push_back(mk(1, 1, 5, 32'hA5A5_A5A5));
      dq.push_back(mk(1, 1, 4, 32'hB4B4_B4B4));
      dq.push_back(mk(1, 1, 6, 32'hB6B6_B6B6));
      run(50, 0, 1);
      chk_val($sformatf("L%0d.tie_stalls", LAT), 32'(obs_stall), 32'd1);
      chk_val($sformatf("L%0d.tie_we_pulses", LAT), 32'(obs_we), 32'd4);

      // Debug read in flight blocks a CPU store; a later debug read sees it.
      clr_obs();
      cq.push_back(mk(0, 0, 0, 32'h0));
      cq.push_back(mk(1, 1, 2, 32'hC0C0_C0C0));
      dq.push_back(mk(1, 0, 2, 32'h0));
      dq.push_back(mk(1, 0, 2, 32'h0));
      run(60, -1, 0);
      chk_val($sformatf("L%0d.drd_block_stalls", LAT), 32'(obs_stall), 32'(LAT));
      chk_val($sformatf("L%0d.drd_store_data", LAT), dbg_rdata, 32'hC0C0_C0C0);

      // Reset one cycle into a CPU load; the load then reissues.
      clr_obs();
      cq.push_back(mk(1, 0, 0, 32'h0));
      run(60, 1, 1);
      chk_val($sformatf("L%0d.rst_rd_stalls", LAT), 32'(obs_stall), 32'(LAT + 2));
      chk_val($sformatf("L%0d.rst_rd_data", LAT), cpu_rdata, 32'hDEAD_BEEF);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 10; c++) begin
        for (int i = 0; i < 14; i++)
          cq.push_back(mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 7)), $urandom));
        for (int i = 0; i < 10; i++)
          dq.push_back(mk($urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)),
                          int'($urandom_range(0, 7)), $urandom));
        run(600, (c % 3 == 2) ? int'($urandom_range(1, 8)) : -1, 1);
      end
      fin = 1'b1;
    end
  end

  initial begin : p_end
    bit all_fin;
    all_fin = 1'b0;
    for (int t = 0; t < 60000 && !all_fin; t++) begin
      @(posedge clk);
      all_fin = g_inst[0].fin && g_inst[1].fin && g_inst[2].fin;
    end
    chk_val("all_instances_done", 32'(all_fin), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
